// File: rtl/ring_freq_counter.sv
// rtl/ring_freq_counter.sv - gated edge counter for a selectable ring oscillator with 3-byte readout
module ring_freq_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ring_in,
  input  logic [2:0] sel,
  input  logic [1:0] win,
  input  logic       start,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GATE = 3'd2,
    HDR  = 3'd3,
    CHI  = 3'd4,
    CLO  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  sel_q;
  logic [11:0] cnt;
  logic        ovf;
  logic [13:0] timer;
  logic        arm_cnt;
  logic        sync1;
  logic        sync2;
  logic        edge_q;
  logic [2:0]  ring_sel;
  logic        rise;
  logic [13:0] gate_last;

  // In IDLE the synchronizer follows the live select so it is already
  // carrying the new ring when start is accepted; afterwards the latched
  // select is used so sel changes while busy cannot disturb the count.
  assign ring_sel = (state == IDLE) ? sel : sel_q;
  assign rise     = sync2 & ~edge_q;

  // Last timer value for the requested gate: W-1 with W = 256 << (2*win).
  always_comb begin
    gate_last = 14'd255;
    case (win)
      2'd0:    gate_last = 14'd255;
      2'd1:    gate_last = 14'd1023;
      2'd2:    gate_last = 14'd4095;
      default: gate_last = 14'd16383;
    endcase
  end

  // Synchronizer and edge flop run regardless of ena so a freeze never
  // leaves a stale level that would look like an edge on resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= ring_in[ring_sel];
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  // Measurement state: FSM register, latched select, window timer, count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= 3'd0;
      cnt     <= 12'd0;
      ovf     <= 1'b0;
      timer   <= 14'd0;
      arm_cnt <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q   <= sel;
            cnt     <= 12'd0;
            ovf     <= 1'b0;
            timer   <= gate_last;
            arm_cnt <= 1'b0;
          end
        end
        ARM: begin
          arm_cnt <= 1'b1;
        end
        GATE: begin
          if (rise) begin
            if (cnt == 12'hFFF) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + 12'd1;
            end
          end
          if (timer != 14'd0) begin
            timer <= timer - 14'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and readout byte; bytes advance only on a completed handshake.
  always_comb begin
    state_nxt  = state;
    dout       = 8'h00;
    dout_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (arm_cnt) begin
          state_nxt = GATE;
        end
      end
      GATE: begin
        if (timer == 14'd0) begin
          state_nxt = HDR;
        end
      end
      HDR: begin
        dout       = {3'b101, ovf, 1'b0, sel_q};
        dout_valid = 1'b1;
        if (dout_ready) begin
          state_nxt = CHI;
        end
      end
      CHI: begin
        dout       = {4'h0, cnt[11:8]};
        dout_valid = 1'b1;
        if (dout_ready) begin
          state_nxt = CLO;
        end
      end
      CLO: begin
        dout       = cnt[7:0];
        dout_valid = 1'b1;
        if (dout_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
